lc3b_control: RTL and testbench

Microsequenced control unit for the LC-3b core, sitting directly upstream of the datapath. It consumes the datapath's IR, the N/Z/P condition codes and the memory ready flag R, and produces every load-enable, bus-gate, ALU-op and memory-write strobe the datapath needs. It runs a fetch/decode/execute state machine with a ready-based memory handshake, a memory-timeout watchdog and a retired-instruction counter.

---
 rtl/lc3b_control.sv | 144 ++++++++++++++
 tb/tb_lc3b_control.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_control.sv
// Microsequenced control unit for the LC-3b core: fetch/decode/execute FSM with
// a ready-based memory handshake, a memory-timeout watchdog and a retired-instruction counter.
module lc3b_control #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] IR,
    input  logic        N,
    input  logic        Z,
    input  logic        P,
    input  logic        R,
    output logic [2:0]  aluop,
    output logic        LDPC,
    output logic        LDMAR,
    output logic        LDMDR,
    output logic        LDIR,
    output logic        LDREG,
    output logic        LDCC,
    output logic        GatePC,
    output logic        GateMDR,
    output logic        GateALU,
    output logic        GateMARMUX,
    output logic        MEMEN,
    output logic        halted,
    output logic        fault,
    output logic [15:0] retired,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        FETCH0 = 4'd0,  FETCH1 = 4'd1,  FETCH2 = 4'd2,  DECODE = 4'd3,
        ALU    = 4'd4,  LDW0   = 4'd5,  LDW1   = 4'd6,  LDW2   = 4'd7,
        STW0   = 4'd8,  STW1   = 4'd9,  DONE   = 4'd10, HALT   = 4'd11
    } state_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [2:0]  aluop_q, aluop_d;
    logic        fault_q, fault_d;
    logic [7:0]  wd_q;
    logic [15:0] retired_q;
    logic        mem_state;
    logic        wd_expired;

    // Branch condition codes and IR operand fields are consumed by the datapath, not here.
    logic unused_inputs;
    assign unused_inputs = ^{IR[11:0], N, Z, P};

    assign mem_state  = (state_q == FETCH1) || (state_q == LDW1) || (state_q == STW1);
    assign wd_expired = mem_state && !R && (wd_q == WD_LAST);

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d = state_q;
        aluop_d = aluop_q;
        fault_d = fault_q;
        case (state_q)
            FETCH0: state_d = FETCH1;
            FETCH1, LDW1, STW1: begin
                if (R) begin
                    state_d = (state_q == FETCH1) ? FETCH2 :
                              (state_q == LDW1)   ? LDW2   : DONE;
                end else if (wd_expired) begin
                    state_d = HALT;
                    fault_d = 1'b1;
                end
            end
            FETCH2: state_d = DECODE;
            DECODE: begin
                case (IR[15:12])
                    4'b0001: begin state_d = ALU; aluop_d = 3'b000; end
                    4'b0101: begin state_d = ALU; aluop_d = 3'b001; end
                    4'b1001: begin state_d = ALU; aluop_d = 3'b010; end
                    4'b0110: state_d = LDW0;
                    4'b0111: state_d = STW0;
                    4'b0000: state_d = DONE;
                    4'b1111: state_d = HALT;
                    default: begin state_d = HALT; fault_d = 1'b1; end
                endcase
            end
            ALU:     state_d = DONE;
            LDW0:    state_d = LDW1;
            LDW2:    state_d = DONE;
            STW0:    state_d = STW1;
            DONE:    state_d = FETCH0;
            HALT:    state_d = HALT;
            default: begin state_d = HALT; fault_d = 1'b1; end
        endcase
    end

    // The watchdog only counts while waiting in place; any state change clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH0;
            aluop_q   <= 3'b000;
            fault_q   <= 1'b0;
            wd_q      <= 8'd0;
            retired_q <= 16'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q   <= state_d;
            aluop_q   <= aluop_d;
            fault_q   <= fault_d;
            wd_q      <= (mem_state && !R && (state_d == state_q)) ? wd_q + 8'd1 : 8'd0;
            retired_q <= retired_q + 16'(state_q == DONE);
        end
    end

    always_comb begin
        aluop      = 3'b000;
        LDPC       = 1'b0;
        LDMAR      = 1'b0;
        LDMDR      = 1'b0;
        LDIR       = 1'b0;
        LDREG      = 1'b0;
        LDCC       = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        MEMEN      = 1'b0;
        halted     = 1'b0;
        case (state_q)
            FETCH0: begin GatePC = 1'b1; LDMAR = 1'b1; LDPC = 1'b1; end
            FETCH1: LDMDR = R;
            FETCH2: LDIR = 1'b1;
            ALU:    begin GateALU = 1'b1; LDREG = 1'b1; LDCC = 1'b1; aluop = aluop_q; end
            LDW0:   begin GateMARMUX = 1'b1; LDMAR = 1'b1; end
            LDW1:   LDMDR = R;
            LDW2:   begin GateMDR = 1'b1; LDREG = 1'b1; end
            STW0:   begin GateMARMUX = 1'b1; LDMAR = 1'b1; end
            STW1:   MEMEN = 1'b1;
            HALT:   halted = 1'b1;
            default: ;
        endcase
    end

    assign fault   = fault_q;
    assign retired = retired_q;
    assign state   = state_q;

endmodule

// File: tb/tb_lc3b_control.sv
// Scoreboard bench for lc3b_control: the stimulus process pushes the expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_lc3b_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] IR = 16'h0000;
    logic        N = 1'b0, Z = 1'b0, P = 1'b0, R = 1'b0;
    logic [2:0]  aluop;
    logic        LDPC, LDMAR, LDMDR, LDIR, LDREG, LDCC;
    logic        GatePC, GateMDR, GateALU, GateMARMUX, MEMEN, halted, fault;
    logic [15:0] retired;
    logic [3:0]  state;

    always #5 clk = ~clk;

    lc3b_control #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .IR(IR), .N(N), .Z(Z), .P(P), .R(R),
        .aluop(aluop), .LDPC(LDPC), .LDMAR(LDMAR), .LDMDR(LDMDR), .LDIR(LDIR),
        .LDREG(LDREG), .LDCC(LDCC), .GatePC(GatePC), .GateMDR(GateMDR),
        .GateALU(GateALU), .GateMARMUX(GateMARMUX), .MEMEN(MEMEN),
        .halted(halted), .fault(fault), .retired(retired), .state(state)
    );

    typedef struct {
        logic [19:0] vec;
        logic [15:0] ret;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          applied = 0;
    int          miscompares = 0;
    logic [15:0] rt = 16'h0000;

    // Strobe bit positions within the 13-bit strobe field.
    localparam int B_LDPC = 12, B_LDMAR = 11, B_LDMDR = 10, B_LDIR = 9, B_LDREG = 8;
    localparam int B_LDCC = 7, B_GPC = 6, B_GMDR = 5, B_GALU = 4, B_GMARMUX = 3;
    localparam int B_MEMEN = 2, B_HALTED = 1, B_FAULT = 0;

    // Expected outputs straight from the per-state output table.
    function automatic logic [19:0] ref_vec(logic [3:0] st, logic r, logic [2:0] op, logic flt);
        logic [2:0]  a;
        logic [12:0] s;
        a = 3'b000;
        s = '0;
        case (st)
            4'd0:  begin s[B_GPC] = 1'b1; s[B_LDMAR] = 1'b1; s[B_LDPC] = 1'b1; end
            4'd1:  s[B_LDMDR] = r;
            4'd2:  s[B_LDIR] = 1'b1;
            4'd4:  begin s[B_GALU] = 1'b1; s[B_LDREG] = 1'b1; s[B_LDCC] = 1'b1; a = op; end
            4'd5:  begin s[B_GMARMUX] = 1'b1; s[B_LDMAR] = 1'b1; end
            4'd6:  s[B_LDMDR] = r;
            4'd7:  begin s[B_GMDR] = 1'b1; s[B_LDREG] = 1'b1; end
            4'd8:  begin s[B_GMARMUX] = 1'b1; s[B_LDMAR] = 1'b1; end
            4'd9:  s[B_MEMEN] = 1'b1;
            4'd11: begin s[B_HALTED] = 1'b1; s[B_FAULT] = flt; end
            default: ;
        endcase
        return {st, a, s};
    endfunction

    logic [19:0] act;
    assign act = {state, aluop, LDPC, LDMAR, LDMDR, LDIR, LDREG, LDCC,
                  GatePC, GateMDR, GateALU, GateMARMUX, MEMEN, halted, fault};

    exp_t e;
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            e = sb.pop_front();
            applied++;
            if (act !== e.vec || retired !== e.ret) begin
                miscompares++;
                $display("FAIL %s: got state=%0d outs=%h retired=%h, expected state=%0d outs=%h retired=%h",
                         e.name, state, act, retired, e.vec[19:16], e.vec, e.ret);
            end
        end
    end

    // One clock: drive inputs, queue the expected outputs for this cycle, advance.
    task automatic cyc(input logic rs, input logic [15:0] ir, input logic r,
                       input logic [3:0] st, input logic [2:0] op, input logic flt,
                       input string nm);
        exp_t x;
        reset = rs;
        IR    = ir;
        R     = r;
        x.vec  = ref_vec(st, r, op, flt);
        x.ret  = rt;
        x.name = nm;
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (rs) rt = 16'h0000;
        else if (st == 4'd10) rt = rt + 16'd1;
    endtask

    task automatic rst_pulse();
        reset = 1'b1;
        R     = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        rt    = 16'h0000;
    endtask

    // R is held high outside memory states to show it is ignored there.
    task automatic fetch_decode(input logic [15:0] ir, input string nm);
        cyc(1'b0, ir, 1'b1, 4'd0, 3'b000, 1'b0, {nm, "/fetch0"});
        cyc(1'b0, ir, 1'b1, 4'd1, 3'b000, 1'b0, {nm, "/fetch1"});
        cyc(1'b0, ir, 1'b1, 4'd2, 3'b000, 1'b0, {nm, "/fetch2"});
        cyc(1'b0, ir, 1'b1, 4'd3, 3'b000, 1'b0, {nm, "/decode"});
    endtask

    task automatic run_alu(input logic [15:0] ir, input logic [2:0] op, input string nm);
        fetch_decode(ir, nm);
        cyc(1'b0, ir, 1'b1, 4'd4, op, 1'b0, {nm, "/alu"});
        cyc(1'b0, ir, 1'b1, 4'd10, 3'b000, 1'b0, {nm, "/done"});
    endtask

    task automatic run_ldw(input logic [15:0] ir, input int waits, input string nm);
        fetch_decode(ir, nm);
        cyc(1'b0, ir, 1'b1, 4'd5, 3'b000, 1'b0, {nm, "/ldw0"});
        for (int i = 0; i < waits; i++)
            cyc(1'b0, ir, 1'b0, 4'd6, 3'b000, 1'b0, {nm, "/ldw1_wait"});
        cyc(1'b0, ir, 1'b1, 4'd6, 3'b000, 1'b0, {nm, "/ldw1_ready"});
        cyc(1'b0, ir, 1'b0, 4'd7, 3'b000, 1'b0, {nm, "/ldw2"});
        cyc(1'b0, ir, 1'b0, 4'd10, 3'b000, 1'b0, {nm, "/done"});
    endtask

    task automatic run_stw(input logic [15:0] ir, input int waits, input string nm);
        fetch_decode(ir, nm);
        cyc(1'b0, ir, 1'b1, 4'd8, 3'b000, 1'b0, {nm, "/stw0"});
        for (int i = 0; i < waits; i++)
            cyc(1'b0, ir, 1'b0, 4'd9, 3'b000, 1'b0, {nm, "/stw1_wait"});
        cyc(1'b0, ir, 1'b1, 4'd9, 3'b000, 1'b0, {nm, "/stw1_ready"});
        cyc(1'b0, ir, 1'b0, 4'd10, 3'b000, 1'b0, {nm, "/done_memen_low"});
    endtask

    task automatic run_nop(input string nm);
        fetch_decode(16'h0000, nm);
        cyc(1'b0, 16'h0000, 1'b1, 4'd10, 3'b000, 1'b0, {nm, "/done"});
    endtask

    task automatic run_halt(input logic [15:0] ir, input logic flt, input string nm);
        fetch_decode(ir, nm);
        for (int i = 0; i < 3; i++)
            cyc(1'b0, ir, logic'(i[0]), 4'd11, 3'b000, flt, {nm, "/halt"});
    endtask

    initial begin
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_alu(16'h1283, 3'b000, "add");
        run_ldw(16'h6285, 3, "ldw_wait3");
        run_stw(16'h7285, 2, "stw_wait2");
        run_nop("nop");
        run_alu(16'h5283, 3'b001, "and");
        run_alu(16'h9283, 3'b010, "not");
        run_ldw(16'h6285, 0, "ldw_fast");
        run_stw(16'h7285, 0, "stw_fast");
        run_halt(16'hF025, 1'b0, "trap");

        rst_pulse();
        run_halt(16'hD000, 1'b1, "illegal");

        rst_pulse();
        cyc(1'b0, 16'h1283, 1'b1, 4'd0, 3'b000, 1'b0, "timeout/fetch0");
        for (int i = 0; i < 16; i++)
            cyc(1'b0, 16'h1283, 1'b0, 4'd1, 3'b000, 1'b0, "timeout/fetch1_wait");
        cyc(1'b0, 16'h1283, 1'b0, 4'd11, 3'b000, 1'b1, "timeout/halt");
        cyc(1'b0, 16'h1283, 1'b1, 4'd11, 3'b000, 1'b1, "timeout/halt_hold");

        rst_pulse();
        fetch_decode(16'h6285, "rst_ldw");
        cyc(1'b0, 16'h6285, 1'b0, 4'd5, 3'b000, 1'b0, "rst_ldw/ldw0");
        cyc(1'b0, 16'h6285, 1'b0, 4'd6, 3'b000, 1'b0, "rst_ldw/ldw1_wait");
        cyc(1'b1, 16'h6285, 1'b0, 4'd6, 3'b000, 1'b0, "rst_ldw/ldw1_reset");
        fetch_decode(16'h7285, "rst_stw");
        cyc(1'b0, 16'h7285, 1'b0, 4'd8, 3'b000, 1'b0, "rst_stw/stw0");
        cyc(1'b0, 16'h7285, 1'b0, 4'd9, 3'b000, 1'b0, "rst_stw/stw1_wait");
        cyc(1'b1, 16'h7285, 1'b0, 4'd9, 3'b000, 1'b0, "rst_stw/stw1_reset");
        run_nop("after_reset_nop");

        // Preload the counter near its wrap point instead of running 65534 NOPs.
        rst_pulse();
        force dut.retired_q = 16'hFFFE;
        #1;
        release dut.retired_q;
        rt = 16'hFFFE;
        run_nop("wrap_a");
        run_nop("wrap_b");
        cyc(1'b0, 16'h0000, 1'b1, 4'd0, 3'b000, 1'b0, "wrap/retired_zero");

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
